// File: rtl/encode_pkg.sv
// Shared definitions for the priority encoder/arbiter.
//   state_t    : arbiter FSM state (IDLE, GRANT)
//   MODE_FIXED : mode input value selecting fixed priority (index 0 highest)
//   MODE_RR    : mode input value selecting round-robin
package encode_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pe_find_first.sv
// Combinational find-first-set: reports the lowest set bit of req.
//   req   in  N  input vector
//   idx   out W  index of the lowest set bit (0 when none set)
//   found out 1  at least one bit of req is set
module pe_find_first #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (req[k] && !found) begin
                idx   = W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encode_priority_arb.sv
// Registered N-input priority encoder/arbiter with fixed-priority and
// round-robin modes, grant hold until release, and optional hold timeout.
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset
//   I     in  N  request lines
//   mode  in  1  0 = fixed priority, 1 = round-robin (sampled in IDLE only)
//   done  in  1  grant holder finished (used in GRANT only)
//   Y     out W  encoded index of the granted requester
//   V     out 1  grant valid
//   gnt   out N  one-hot grant
//   tout  out 1  one-cycle pulse on a release caused only by the timeout
module encode_priority_arb
    import encode_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] I,
    input  logic         mode,
    input  logic         done,
    output logic [W-1:0] Y,
    output logic         V,
    output logic [N-1:0] gnt,
    output logic         tout
);

    // Counter keeps at least one bit so MAX_HOLD=0 (timeout disabled) still elaborates.
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           v_q, v_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           tout_q, tout_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   req_masked;
    logic [W-1:0]   idx_all, idx_msk, win_idx;
    logic           found_all, found_msk;
    logic           holder_req, timeout_hit, release_now;

    // Round-robin candidates: only requesters at or above ptr.
    always_comb begin
        req_masked = '0;
        for (int unsigned k = 0; k < N; k++) begin
            req_masked[k] = I[k] && (W'(k) >= ptr_q);
        end
    end

    pe_find_first #(.N(N)) u_ff_all (
        .req   (I),
        .idx   (idx_all),
        .found (found_all)
    );

    pe_find_first #(.N(N)) u_ff_msk (
        .req   (req_masked),
        .idx   (idx_msk),
        .found (found_msk)
    );

    // Empty masked set means wrap-around: fall back to the unmasked winner.
    assign win_idx = (mode == MODE_RR && found_msk) ? idx_msk : idx_all;

    assign holder_req  = I[y_q];
    assign timeout_hit = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));
    assign release_now = done || !holder_req || timeout_hit;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        v_d     = v_q;
        gnt_d   = gnt_q;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found_all) begin
                    y_d          = win_idx;
                    v_d          = 1'b1;
                    gnt_d        = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d        = '0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    v_d     = 1'b0;
                    gnt_d   = '0;
                    // Pointer advances past the holder in both modes.
                    ptr_d   = (y_q == W'(N - 1)) ? '0 : y_q + W'(1);
                    tout_d  = timeout_hit && !done && holder_req;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            ptr_q   <= '0;
            v_q     <= 1'b0;
            gnt_q   <= '0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            v_q     <= v_d;
            gnt_q   <= gnt_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Y    = y_q;
    assign V    = v_q;
    assign gnt  = gnt_q;
    assign tout = tout_q;

endmodule

// File: tb/tb_encode_priority_arb.sv
// Self-checking bench for encode_priority_arb. Three instances share one clock:
// N=8/MAX_HOLD=16 (main), N=8/MAX_HOLD=4 (timeout), N=5/MAX_HOLD=0 (wrap).
module tb_encode_priority_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] i_m = '0;  logic mode_m = 1'b0; logic done_m = 1'b0;
    logic [2:0] y_m;       logic v_m; logic [7:0] gnt_m; logic tout_m;
    logic [7:0] i_t = '0;  logic mode_t = 1'b0; logic done_t = 1'b0;
    logic [2:0] y_t;       logic v_t; logic [7:0] gnt_t; logic tout_t;
    logic [4:0] i_f = '0;  logic mode_f = 1'b0; logic done_f = 1'b0;
    logic [2:0] y_f;       logic v_f; logic [4:0] gnt_f; logic tout_f;

    encode_priority_arb #(.N(8), .MAX_HOLD(16)) u_main (
        .clk(clk), .rst(rst), .I(i_m), .mode(mode_m), .done(done_m),
        .Y(y_m), .V(v_m), .gnt(gnt_m), .tout(tout_m)
    );
    encode_priority_arb #(.N(8), .MAX_HOLD(4)) u_to (
        .clk(clk), .rst(rst), .I(i_t), .mode(mode_t), .done(done_t),
        .Y(y_t), .V(v_t), .gnt(gnt_t), .tout(tout_t)
    );
    encode_priority_arb #(.N(5), .MAX_HOLD(0)) u_n5 (
        .clk(clk), .rst(rst), .I(i_f), .mode(mode_f), .done(done_f),
        .Y(y_f), .V(v_f), .gnt(gnt_f), .tout(tout_f)
    );

    typedef struct {
        int         sel;
        string      tag;
        logic       v;
        logic [2:0] y;
        logic [7:0] gnt;
        logic       tout;
    } exp_t;

    typedef struct {
        logic [7:0] i;
        logic       md;
        logic       dn;
        logic       v;
        logic [2:0] y;
        logic [7:0] gnt;
        logic       tout;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[14];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on the selected instance, queue the expected
    // post-edge outputs, then pop and compare them 1 time unit after the edge.
    task automatic step(input int sel, input string tag, input logic [7:0] i,
                        input logic md, input logic dn, input logic ev,
                        input logic [2:0] ey, input logic [7:0] eg, input logic et);
        exp_t e;
        @(negedge clk);
        case (sel)
            0:       begin i_m = i;      mode_m = md; done_m = dn; end
            1:       begin i_t = i;      mode_t = md; done_t = dn; end
            default: begin i_f = i[4:0]; mode_f = md; done_f = dn; end
        endcase
        e.sel = sel; e.tag = tag; e.v = ev; e.y = ey; e.gnt = eg; e.tout = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (e.sel)
            0: begin
                check({e.tag, ".V"},    32'(v_m),    32'(e.v));
                check({e.tag, ".Y"},    32'(y_m),    32'(e.y));
                check({e.tag, ".gnt"},  32'(gnt_m),  32'(e.gnt));
                check({e.tag, ".tout"}, 32'(tout_m), 32'(e.tout));
            end
            1: begin
                check({e.tag, ".V"},    32'(v_t),    32'(e.v));
                check({e.tag, ".Y"},    32'(y_t),    32'(e.y));
                check({e.tag, ".gnt"},  32'(gnt_t),  32'(e.gnt));
                check({e.tag, ".tout"}, 32'(tout_t), 32'(e.tout));
            end
            default: begin
                check({e.tag, ".V"},    32'(v_f),    32'(e.v));
                check({e.tag, ".Y"},    32'(y_f),    32'(e.y));
                check({e.tag, ".gnt"},  32'({3'b000, gnt_f}), 32'(e.gnt));
                check({e.tag, ".tout"}, 32'(tout_f), 32'(e.tout));
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            I      md    dn    V     Y     gnt    tout
        tbl[0]  = '{8'hA4, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[1]  = '{8'hA4, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[2]  = '{8'hA4, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[3]  = '{8'hA4, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        tbl[4]  = '{8'hA4, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[7]  = '{8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        tbl[8]  = '{8'h21, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        tbl[9]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
        tbl[10] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[11] = '{8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[12] = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
        tbl[13] = '{8'h80, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst.V",    32'(v_m),    32'd0);
        check("rst.Y",    32'(y_m),    32'd0);
        check("rst.gnt",  32'(gnt_m),  32'd0);
        check("rst.tout", 32'(tout_t), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority, release/regrant, withdrawal, no pre-emption.
        for (int k = 0; k < 14; k++) begin
            step(0, $sformatf("tbl%0d", k), tbl[k].i, tbl[k].md, tbl[k].dn,
                 tbl[k].v, tbl[k].y, tbl[k].gnt, tbl[k].tout);
        end

        // Round-robin rotation from ptr=0 with all requesters active.
        for (int k = 0; k < 9; k++) begin
            logic [7:0] one;
            one = 8'h01 << (k % 8);
            step(0, $sformatf("rr%0d_g", k), 8'hFF, 1'b1, 1'b0, 1'b1, 3'(k % 8), one, 1'b0);
            step(0, $sformatf("rr%0d_r", k), 8'hFF, 1'b1, 1'b1, 1'b0, 3'(k % 8), 8'h00, 1'b0);
        end

        // Asynchronous reset in the middle of a grant.
        step(0, "pre_rst", 8'hFF, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        #2;
        i_m = 8'h00;
        rst = 1'b1;
        #1;
        check("arst.V",   32'(v_m),   32'd0);
        check("arst.Y",   32'(y_m),   32'd0);
        check("arst.gnt", 32'(gnt_m), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, "post_rst_idle", 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(0, "post_rst_idle2", 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(0, "ptr_reset_g", 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(0, "ptr_reset_r", 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(0, "main_quiet", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Timeout with MAX_HOLD=4: four valid cycles, then a lone-cause pulse.
        for (int k = 0; k < 4; k++)
            step(1, $sformatf("to_hold%0d", k), 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(1, "to_release", 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        step(1, "to_regrant", 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        for (int k = 0; k < 3; k++)
            step(1, $sformatf("to2_hold%0d", k), 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(1, "to_done_same", 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(1, "to_quiet", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // N=5 round-robin wrap: park ptr at 4, then requests {0,1}.
        step(2, "n5_fix_g", 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        step(2, "n5_fix_r", 8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        step(2, "n5_wrap_g", 8'h03, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(2, "n5_wrap_r", 8'h03, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(2, "n5_next_g", 8'h03, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        step(2, "n5_next_r", 8'h03, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        step(2, "n5_quiet", 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encode_priority_arb.md
# encode_priority_arb

Registered N-input priority encoder/arbiter, the parametrised next generation of the team's 4x2 combinational priority encoder. Selects one of N request lines in fixed-priority mode (bit 0 highest) or round-robin mode. Holds the grant until the winner releases or a hold timeout expires. Sits in front of shared resources (bus port, shared memory bank) where requesters must be serialised.

## Interface
- `N`, 8: number of request lines; N ≥ 2, need not be a power of two.
- `MAX_HOLD`, 16: maximum consecutive GRANT cycles before forced release; 0 disables the timeout.
- `W` (localparam), $clog2(N): index width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `I`  in  N  request lines; I[k]=1 means requester k wants the resource.
- `mode`  in  1  0 = fixed priority (index 0 highest), 1 = round-robin.
- `done`  in  1  current grant holder finished; meaningful only in GRANT.
- `Y`  out  W  encoded index of the granted requester.
- `V`  out  1  a grant is valid (Y/gnt meaningful).
- `gnt`  out  N  one-hot grant, gnt[Y]=1 when V=1, else all zero.
- `tout`  out  1  one-cycle pulse marking a forced release by timeout.

## Operation
- Two-state FSM: IDLE, GRANT. Reset → IDLE.
- IDLE: if I ≠ 0, arbitrate, register the winner into Y/gnt, set V=1, clear hold counter, go to GRANT. If I = 0, stay; V=0, gnt=0, Y holds its last value.
- Fixed mode: the winner is the lowest set index of I.
- Round-robin mode: the winner is the first set index at or above `ptr`, wrapping from N-1 to 0. `ptr` is W bits and resets to 0.
- `mode` is sampled only on the IDLE arbitration edge. Changing it during GRANT has no effect on the current grant.
- GRANT: the grant holds. Release occurs when any of the following is true:
  - done=1
  - I[Y]=0 (requester withdrew)
  - hold counter = MAX_HOLD-1, when MAX_HOLD ≠ 0
- On the release edge:
  - go to IDLE; V=0, gnt=0.
  - `ptr` ← (Y==N-1) ? 0 : Y+1. This happens in both modes, so a later switch to round-robin continues from the last holder.
  - tout=1 for that one cycle only if the timeout was the sole cause. If done or a withdrawal coincides, tout=0.
- Non-holder requests are ignored while in GRANT. No pre-emption, even by index 0 in fixed mode.
- The hold counter saturates-free: it is cleared on entry to GRANT and increments each GRANT cycle. Its width is $clog2(MAX_HOLD+1).
- Reset mid-grant: all outputs clear immediately (asynchronously), ptr=0, state IDLE.

## Timing
- Reset values: Y=0, V=0, gnt=0, tout=0; internal ptr=0, counter=0, state=IDLE.
- All outputs are registered; there is no combinational path from I/done/mode to outputs.
- Grant latency: I sampled non-zero at edge t (state IDLE) → V=1 and valid Y/gnt after edge t.
- Release: done=1 sampled at edge t → V=0 after edge t. The earliest next grant is after edge t+1 (one mandatory dead cycle).
- Timeout: with MAX_HOLD=M, a grant entered at edge t is force-released at edge t+M. V is high for exactly M cycles.
- Back-to-back holder: if the same requester keeps I high through release, it competes normally at the next IDLE edge. In round-robin mode it loses to any other requester.

## Structure
- Shared package `encode_pkg`: FSM state typedef (IDLE, GRANT), mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module `pe_find_first`, parameter N. It is combinational: N-bit input, outputs W-bit index of the lowest set bit plus a found flag.
- Fixed mode uses `pe_find_first` on I directly.
- Round-robin mode uses it on the request vector masked to bits ≥ ptr, falling back to the unmasked vector when the masked result is empty.
- The top level holds the FSM, ptr, hold counter and output registers.

## Test plan
- Reset/idle: assert rst mid-grant with I=8'hFF → V=0, gnt=0, Y=0 immediately. After release with I=0, V stays 0.
- Fixed priority (N=8, mode=0): I=8'b1010_0100 → Y=2, gnt=8'h04, V=1 one edge later. Pulse done → V=0 next edge, then Y=2 again (I unchanged).
- Round-robin rotation (mode=1): I=8'hFF held, done pulsed each grant → grants Y=0,1,2,…,7,0 with one idle cycle between each.
- Round-robin wrap with N=5: ptr=4, I=5'b00011 → Y=0. Then after release, ptr=1 → Y=1.
- Timeout (MAX_HOLD=4): I=8'h01 held, done=0 → V high exactly 4 cycles, tout pulses on the release cycle, then re-grant Y=0. With done=1 on the timeout cycle, tout=0.
- Withdrawal and no pre-emption: grant Y=5, raise I[0] during GRANT → Y stays 5. Drop I[5] → release; the next grant is Y=0 in fixed mode.
